// File: rtl/uart_byte_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter with host RTS flow control.
// Frames are popped from the FIFO only at frame boundaries, back-to-back when data is waiting.
module uart_byte_tx #(
  parameter  int DIV     = 104,
  parameter  int DEPTH   = 16,
  parameter  int USE_RTS = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DIV)
) (
  input  logic          clk12m,
  input  logic          n_reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          rts,
  output logic          tx,
  output logic          busy,
  output logic [AW:0]   fill
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill_q, fill_d;
  logic          in_ready_q, avail_q;
  logic          rts_meta_q, rts_s_q;

  logic wr_en, pop, bit_end, send_ok;

  assign wr_en   = in_valid && in_ready_q;
  assign bit_end = (cnt_q == DIV_M1);
  // The read side sees a new entry one cycle after fill changes (avail_q),
  // so a fresh byte starts its frame on the second edge after the write.
  assign send_ok = avail_q && (fill_q != '0) && (rts_s_q || (USE_RTS == 0));
  assign pop     = send_ok && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign fill_d  = fill_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk12m or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      in_ready_q <= 1'b0;
      avail_q    <= 1'b0;
      rts_meta_q <= 1'b0;
      rts_s_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q     <= fill_d;
      in_ready_q <= (fill_d != FULL);
      avail_q    <= (fill_q != '0);
      rts_meta_q <= rts;
      rts_s_q    <= rts_meta_q;
    end
  end

  always_ff @(posedge clk12m) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk12m or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          tx_q  <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else cnt_q <= cnt_q + CW'(1);
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else cnt_q <= cnt_q + CW'(1);
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else cnt_q <= cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) || (fill_q != '0);
  assign fill     = fill_q;
  assign in_ready = in_ready_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx: stimulus queues expected bytes, a UART
// receiver process decodes tx frames, checks bit timing and compares in order.
module tb_uart_byte_tx;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] id0 = '0, id1 = '0;
  logic iv0 = 1'b0, iv1 = 1'b0, rts0 = 1'b0, rts1 = 1'b0;
  logic rdy0, rdy1, tx0, tx1, busy0, busy1;
  logic [FW-1:0] fill0, fill1;

  int nvec = 0, nerr = 0, cyc = 0;

  typedef struct {
    logic [7:0] data;
    bit         contig;
  } exp_t;
  exp_t exp_q[$];

  uart_byte_tx #(.DIV(DIV), .DEPTH(DEPTH), .USE_RTS(1)) u0 (
    .clk12m(clk), .n_reset(rst_n), .in_data(id0), .in_valid(iv0), .in_ready(rdy0),
    .rts(rts0), .tx(tx0), .busy(busy0), .fill(fill0));

  uart_byte_tx #(.DIV(DIV), .DEPTH(DEPTH), .USE_RTS(0)) u1 (
    .clk12m(clk), .n_reset(rst_n), .in_data(id1), .in_valid(iv1), .in_ready(rdy1),
    .rts(rts1), .tx(tx1), .busy(busy1), .fill(fill1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Receiver: only one instance transmits at a time, the other idles high.
  initial begin : mon
    logic [10*DIV-1:0] samp;
    logic [7:0] d;
    int idx, st, last_end;
    bit inf, ok;
    exp_t e;
    idx = 0; st = 0; last_end = -100; inf = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inf = 0;
        continue;
      end
      if (!inf && (tx0 & tx1) == 1'b0) begin
        inf = 1; idx = 0; st = cyc;
      end
      if (inf) begin
        samp[idx] = tx0 & tx1;
        idx++;
        if (idx == 10*DIV) begin
          inf = 0;
          ok = 1;
          for (int b = 0; b < 10; b++)
            for (int k = 0; k < DIV; k++)
              if (samp[b*DIV+k] !== samp[b*DIV]) ok = 0;
          chk("bit_timing", 32'(ok), 32'd1);
          chk("stop_bit", 32'(samp[9*DIV]), 32'd1);
          for (int i = 0; i < 8; i++) d[i] = samp[(i+1)*DIV];
          if (exp_q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_frame: got %02h required no frame", d);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", 32'(d), 32'(e.data));
            if (e.contig) chk("frame_gap", 32'(st), 32'(last_end + 1));
          end
          last_end = cyc;
        end
      end
    end
  end

  // Called and returns on a falling edge; holds valid until accepted.
  task automatic offer(input int inst, input logic [7:0] d, input bit contig);
    int n = 0;
    if (inst == 0) begin iv0 = 1'b1; id0 = d; end
    else           begin iv1 = 1'b1; id1 = d; end
    while (!((inst == 0) ? rdy0 : rdy1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: in_ready stayed 0 for byte %02h", d);
    end else begin
      exp_q.push_back('{data: d, contig: contig});
    end
    @(negedge clk);
    iv0 = 1'b0;
    iv1 = 1'b0;
  endtask

  task automatic wait_tx_low();
    int n = 0;
    while ((tx0 & tx1) !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      nvec++; nerr++;
      $display("FAIL start_timeout: tx stayed 1, required 0");
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy0 || busy1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: %0d frames outstanding, busy=%b%b, required 0", exp_q.size(), busy0, busy1);
    end
  endtask

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_fill", 32'(fill0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_tx1", 32'(tx1), 32'd1);
    rts0 = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy0), 32'd1);
    chk("ready1_after_rst", 32'(rdy1), 32'd1);
    repeat (4) @(negedge clk);

    // 0xA5: start latency and busy fall after stop
    offer(0, 8'hA5, 0);
    chk("fill_after_write", 32'(fill0), 32'd1);
    chk("tx_idle_e0", 32'(tx0), 32'd1);
    @(negedge clk);
    chk("tx_idle_e1", 32'(tx0), 32'd1);
    @(negedge clk);
    chk("tx_start_e2", 32'(tx0), 32'd0);
    chk("fill_after_pop", 32'(fill0), 32'd0);
    repeat (39) @(negedge clk);
    chk("busy_in_stop", 32'(busy0), 32'd1);
    chk("tx_stop", 32'(tx0), 32'd1);
    @(negedge clk);
    chk("busy_after_stop", 32'(busy0), 32'd0);

    // 0x00 then 0xFF on consecutive cycles: contiguous frames
    iv0 = 1'b1; id0 = 8'h00;
    chk("rdy_b2b_0", 32'(rdy0), 32'd1);
    exp_q.push_back('{data: 8'h00, contig: 1'b0});
    @(negedge clk);
    id0 = 8'hFF;
    chk("rdy_b2b_1", 32'(rdy0), 32'd1);
    exp_q.push_back('{data: 8'hFF, contig: 1'b1});
    @(negedge clk);
    iv0 = 1'b0;
    drain();

    // Full FIFO with rts low, then release
    rts0 = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) offer(0, 8'(8'h11 * (i + 1)), 0);
    iv0 = 1'b1; id0 = 8'h55;
    repeat (20) @(negedge clk);
    chk("rdy_full", 32'(rdy0), 32'd0);
    chk("fill_full", 32'(fill0), 32'd4);
    chk("tx_held", 32'(tx0), 32'd1);
    rts0 = 1'b1;
    offer(0, 8'h55, 0);
    offer(0, 8'h66, 0);
    drain();

    // rts dropped mid-frame: frame completes, next waits for rts
    offer(0, 8'h3C, 0);
    offer(0, 8'hC3, 0);
    wait_tx_low();
    repeat (12) @(negedge clk);
    rts0 = 1'b0;
    n = 0;
    while (exp_q.size() > 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("first_frame_done", 32'(exp_q.size()), 32'd1);
    repeat (30) @(negedge clk);
    chk("tx_paused", 32'(tx0), 32'd1);
    chk("fill_paused", 32'(fill0), 32'd1);
    chk("busy_paused", 32'(busy0), 32'd1);
    rts0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("tx_sync_lat", 32'(tx0), 32'd1);
    @(negedge clk);
    chk("tx_resume", 32'(tx0), 32'd0);
    drain();

    // Reset during data bit 3 of 0x37 with 0x81 still buffered
    offer(0, 8'h37, 0);
    offer(0, 8'h81, 0);
    wait_tx_low();
    repeat (17) @(negedge clk);
    chk("tx_bit3", 32'(tx0), 32'd0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("tx_async_rst", 32'(tx0), 32'd1);
    chk("fill_async_rst", 32'(fill0), 32'd0);
    chk("busy_async_rst", 32'(busy0), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst2", 32'(rdy0), 32'd1);
    offer(0, 8'h96, 0);
    drain();

    // USE_RTS=0 instance with rts held low
    offer(1, 8'hE1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("tx1_start", 32'(tx1), 32'd0);
    offer(1, 8'h4B, 1);
    drain();
    chk("fill1_end", 32'(fill1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin : watchdog
    #400000;
    nerr++;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "watchdog expired");
  end

endmodule
